// File: rtl/mae_pkg.sv
// mae_pkg -- shared types and helpers for the multiply/accumulate pipeline.
//   mae_post_e   : post-adder mode (product only, product+C, accumulate)
//   mae_sat_max  : largest value of a signed/unsigned range of a given width
//   mae_sat_min  : smallest value of a signed/unsigned range of a given width
// The limit functions return MAE_MAX_W bits; callers slice to their width.
package mae_pkg;

  typedef enum logic [1:0] {
    MAE_POST_NONE = 2'd0,
    MAE_POST_ADDC = 2'd1,
    MAE_POST_ACC  = 2'd2
  } mae_post_e;

  localparam int unsigned MAE_MAX_W = 256;

  // Upper clamp limit: 2^(w-1)-1 for signed, 2^w-1 for unsigned.
  function automatic logic [MAE_MAX_W-1:0] mae_sat_max(input logic is_signed,
                                                       input int unsigned width);
    logic [MAE_MAX_W-1:0] ones_v;
    ones_v = {MAE_MAX_W{1'b1}};
    if (is_signed) begin
      mae_sat_max = ones_v >> (MAE_MAX_W - width + 32'd1);
    end else begin
      mae_sat_max = ones_v >> (MAE_MAX_W - width);
    end
  endfunction

  // Lower clamp limit: -2^(w-1) (as a w-bit pattern) for signed, 0 for unsigned.
  function automatic logic [MAE_MAX_W-1:0] mae_sat_min(input logic is_signed,
                                                       input int unsigned width);
    logic [MAE_MAX_W-1:0] one_v;
    one_v = {{(MAE_MAX_W-1){1'b0}}, 1'b1};
    if (is_signed) begin
      mae_sat_min = one_v << (width - 32'd1);
    end else begin
      mae_sat_min = {MAE_MAX_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/mae_stage.sv
// mae_stage -- one bypassable pipeline register.
//   CLK    : rising-edge clock
//   ARST_N : asynchronous active-low clear
//   SRST_N : synchronous active-low clear, wins over CE
//   CE     : clock enable, 0 holds the register
//   D / Q  : W-bit data in / out
// With BYPASS=1 the stage is a wire and the control inputs are ignored.
module mae_stage #(
  parameter int W      = 1,
  parameter bit BYPASS = 1'b0
) (
  input  logic         CLK,
  input  logic         ARST_N,
  input  logic         SRST_N,
  input  logic         CE,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  if (BYPASS) begin : g_bypass
    logic unused_ctl_s;
    assign unused_ctl_s = ^{CLK, ARST_N, SRST_N, CE};
    assign Q = D;
  end else begin : g_reg
    logic [W-1:0] q_r;

    // Stage register: async clear, then sync clear regardless of CE, then CE load.
    always_ff @(posedge CLK or negedge ARST_N) begin
      if (!ARST_N) begin
        q_r <= {W{1'b0}};
      end else if (!SRST_N) begin
        q_r <= {W{1'b0}};
      end else if (CE) begin
        q_r <= D;
      end
    end

    assign Q = q_r;
  end

endmodule

// File: rtl/mae_pipe.sv
// mae_pipe -- pipelined multiplier with optional post-adder / accumulator.
//   CLK, ARST_N, SRST_N, CE : clock, async clear, sync clear, clock enable
//   A, B                    : multiplier operands (signed if SIGNED=1)
//   C                       : addend for ADDC mode, travels with A/B
//   IN_VALID, ACC_CLR       : operation valid / accumulator load, travel with data
//   P, OUT_VALID, OVF       : result, result valid, saturation flag
// Stages: input (REG_IN) -> product (REG_M) -> output/accumulator (REG_P).
// Build option: define MAE_SAT_EN for saturating ADDC/ACC arithmetic with OVF;
// without it results wrap and OVF is always 0.
module mae_pipe
  import mae_pkg::*;
#(
  parameter int        A_WIDTH   = 18,
  parameter int        B_WIDTH   = 18,
  parameter int        P_WIDTH   = 40,
  parameter int        SIGNED    = 1,
  parameter int        REG_IN    = 1,
  parameter int        REG_M     = 0,
  parameter int        REG_P     = 1,
  parameter mae_post_e POST_MODE = MAE_POST_NONE
) (
  input  logic               CLK,
  input  logic               ARST_N,
  input  logic               SRST_N,
  input  logic               CE,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [P_WIDTH-1:0] C,
  input  logic               IN_VALID,
  input  logic               ACC_CLR,
  output logic [P_WIDTH-1:0] P,
  output logic               OUT_VALID,
  output logic               OVF
);

  localparam int AB_W = A_WIDTH + B_WIDTH;
  localparam int IN_W = 2 + P_WIDTH + A_WIDTH + B_WIDTH;  // clr, valid, C, B, A
  localparam int M_W  = 2 + 2 * P_WIDTH;                  // clr, valid, C, product
  localparam int O_W  = 2 + P_WIDTH;                      // ovf, valid, result

  if (P_WIDTH < AB_W) begin : g_chk_width
    $error("mae_pipe: P_WIDTH must be at least A_WIDTH + B_WIDTH");
  end
  if ((POST_MODE == MAE_POST_ACC) && (REG_P == 32'sd0)) begin : g_chk_acc
    $error("mae_pipe: accumulate mode needs REG_P = 1");
  end

  // ---------------------------------------------------------------- input stage
  logic [IN_W-1:0]    in_d_s;
  logic [IN_W-1:0]    in_q_s;
  logic [A_WIDTH-1:0] a_i_s;
  logic [B_WIDTH-1:0] b_i_s;
  logic [P_WIDTH-1:0] c_i_s;
  logic               vld_i_s;
  logic               clr_i_s;

  assign in_d_s = {ACC_CLR, IN_VALID, C, B, A};

  mae_stage #(.W(IN_W), .BYPASS(REG_IN == 32'sd0)) u_stage_in (
    .CLK    (CLK),
    .ARST_N (ARST_N),
    .SRST_N (SRST_N),
    .CE     (CE),
    .D      (in_d_s),
    .Q      (in_q_s)
  );

  assign {clr_i_s, vld_i_s, c_i_s, b_i_s, a_i_s} = in_q_s;

  // ------------------------------------------------------------------ product
  // Operands are widened to the full product width first so the multiply is
  // exact; the product is then extended to P_WIDTH with the operand signedness.
  logic [P_WIDTH-1:0] prod_s;

  if (SIGNED != 32'sd0) begin : g_sgn
    logic signed [AB_W-1:0] a_ext_s;
    logic signed [AB_W-1:0] b_ext_s;
    logic signed [AB_W-1:0] prod_full_s;
    assign a_ext_s     = AB_W'($signed(a_i_s));
    assign b_ext_s     = AB_W'($signed(b_i_s));
    assign prod_full_s = a_ext_s * b_ext_s;
    assign prod_s      = P_WIDTH'(prod_full_s);
  end else begin : g_uns
    logic [AB_W-1:0] a_ext_s;
    logic [AB_W-1:0] b_ext_s;
    logic [AB_W-1:0] prod_full_s;
    assign a_ext_s     = AB_W'(a_i_s);
    assign b_ext_s     = AB_W'(b_i_s);
    assign prod_full_s = a_ext_s * b_ext_s;
    assign prod_s      = P_WIDTH'(prod_full_s);
  end

  // ------------------------------------------------------------ product stage
  logic [M_W-1:0]     m_d_s;
  logic [M_W-1:0]     m_q_s;
  logic [P_WIDTH-1:0] prod_m_s;
  logic [P_WIDTH-1:0] c_m_s;
  logic               vld_m_s;
  logic               clr_m_s;

  assign m_d_s = {clr_i_s, vld_i_s, c_i_s, prod_s};

  mae_stage #(.W(M_W), .BYPASS(REG_M == 32'sd0)) u_stage_m (
    .CLK    (CLK),
    .ARST_N (ARST_N),
    .SRST_N (SRST_N),
    .CE     (CE),
    .D      (m_d_s),
    .Q      (m_q_s)
  );

  assign {clr_m_s, vld_m_s, c_m_s, prod_m_s} = m_q_s;

  // --------------------------------------------------------------- post-adder
  logic [P_WIDTH-1:0] acc_fb_s;   // current accumulator (ACC mode only)
  logic               ovf_fb_s;   // current flag, held across bubbles
  logic [P_WIDTH-1:0] addend_s;
  logic [P_WIDTH-1:0] res_s;
  logic               res_ovf_s;
  logic [P_WIDTH-1:0] p_res_s;
  logic               p_vld_s;
  logic               p_ovf_s;

  // Feedback exists only in accumulate mode, so no loop forms when REG_P bypasses.
  if (POST_MODE == MAE_POST_ACC) begin : g_acc_fb
    assign acc_fb_s = p_res_s;
    assign ovf_fb_s = p_ovf_s;
  end else begin : g_no_fb
    assign acc_fb_s = {P_WIDTH{1'b0}};
    assign ovf_fb_s = 1'b0;
  end

  // Second adder operand: C, the accumulator, or zero (product only / ACC load).
  always_comb begin
    addend_s = {P_WIDTH{1'b0}};
    case (POST_MODE)
      MAE_POST_ADDC: addend_s = c_m_s;
      MAE_POST_ACC: begin
        if (clr_m_s) begin
          addend_s = {P_WIDTH{1'b0}};
        end else begin
          addend_s = acc_fb_s;
        end
      end
      default: addend_s = {P_WIDTH{1'b0}};
    endcase
  end

`ifdef MAE_SAT_EN
  localparam logic [P_WIDTH-1:0] SAT_MAX = P_WIDTH'(mae_sat_max(SIGNED != 32'sd0, P_WIDTH));
  localparam logic [P_WIDTH-1:0] SAT_MIN = P_WIDTH'(mae_sat_min(SIGNED != 32'sd0, P_WIDTH));

  logic [P_WIDTH-1:0] sum_s;
  logic               carry_s;
  logic               ovf_raw_s;

  assign {carry_s, sum_s} = {1'b0, prod_m_s} + {1'b0, addend_s};

  // Overflow detect and clamp; signed overflow direction follows the operand sign.
  always_comb begin
    ovf_raw_s = 1'b0;
    res_s     = sum_s;
    res_ovf_s = 1'b0;
    if (SIGNED != 32'sd0) begin
      ovf_raw_s = (prod_m_s[P_WIDTH-1] == addend_s[P_WIDTH-1]) &&
                  (sum_s[P_WIDTH-1] != prod_m_s[P_WIDTH-1]);
    end else begin
      ovf_raw_s = carry_s;
    end
    if (ovf_raw_s) begin
      res_ovf_s = 1'b1;
      if ((SIGNED != 32'sd0) && prod_m_s[P_WIDTH-1]) begin
        res_s = SAT_MIN;
      end else begin
        res_s = SAT_MAX;
      end
    end else begin
      res_ovf_s = 1'b0;
      res_s     = sum_s;
    end
  end
`else
  assign res_s     = prod_m_s + addend_s;
  assign res_ovf_s = 1'b0;
`endif

  // ------------------------------------------------------------- output stage
  logic [O_W-1:0] o_d_s;
  logic [O_W-1:0] o_q_s;

  // In ACC mode a bubble keeps result and flag and only drops the valid bit.
  always_comb begin
    o_d_s = {res_ovf_s, vld_m_s, res_s};
    if ((POST_MODE == MAE_POST_ACC) && !vld_m_s) begin
      o_d_s = {ovf_fb_s, 1'b0, acc_fb_s};
    end else begin
      o_d_s = {res_ovf_s, vld_m_s, res_s};
    end
  end

  mae_stage #(.W(O_W), .BYPASS(REG_P == 32'sd0)) u_stage_p (
    .CLK    (CLK),
    .ARST_N (ARST_N),
    .SRST_N (SRST_N),
    .CE     (CE),
    .D      (o_d_s),
    .Q      (o_q_s)
  );

  assign {p_ovf_s, p_vld_s, p_res_s} = o_q_s;

  assign P         = p_res_s;
  assign OUT_VALID = p_vld_s;
  assign OVF       = p_ovf_s;

endmodule

// File: tb/tb_mae_pipe.sv
// tb_mae_pipe -- directed self-checking bench for mae_pipe.
// Four instances share the input bus:
//   u0 defaults (NONE, L=2)          u1 ADDC, fully combinational (L=0)
//   u2 ACC, REG_IN=REG_M=REG_P=1 (L=3) u3 unsigned, NONE, REG_M only (L=1)
module tb_mae_pipe;
  import mae_pkg::*;

  logic        clk;
  logic        arst_n;
  logic        srst_n;
  logic        ce;
  logic [17:0] a;
  logic [17:0] b;
  logic [39:0] c;
  logic        in_valid;
  logic        acc_clr;

  logic [39:0] p0, p1, p2, p3;
  logic        v0, v1, v2, v3;
  logic        o0, o1, o2, o3;

  int n_chk  = 0;
  int n_pass = 0;

  mae_pipe u0 (
    .CLK(clk), .ARST_N(arst_n), .SRST_N(srst_n), .CE(ce), .A(a), .B(b), .C(c),
    .IN_VALID(in_valid), .ACC_CLR(acc_clr), .P(p0), .OUT_VALID(v0), .OVF(o0)
  );

  mae_pipe #(.REG_IN(0), .REG_M(0), .REG_P(0), .POST_MODE(MAE_POST_ADDC)) u1 (
    .CLK(clk), .ARST_N(arst_n), .SRST_N(srst_n), .CE(ce), .A(a), .B(b), .C(c),
    .IN_VALID(in_valid), .ACC_CLR(acc_clr), .P(p1), .OUT_VALID(v1), .OVF(o1)
  );

  mae_pipe #(.REG_IN(1), .REG_M(1), .REG_P(1), .POST_MODE(MAE_POST_ACC)) u2 (
    .CLK(clk), .ARST_N(arst_n), .SRST_N(srst_n), .CE(ce), .A(a), .B(b), .C(c),
    .IN_VALID(in_valid), .ACC_CLR(acc_clr), .P(p2), .OUT_VALID(v2), .OVF(o2)
  );

  mae_pipe #(.SIGNED(0), .REG_IN(0), .REG_M(1), .REG_P(0)) u3 (
    .CLK(clk), .ARST_N(arst_n), .SRST_N(srst_n), .CE(ce), .A(a), .B(b), .C(c),
    .IN_VALID(in_valid), .ACC_CLR(acc_clr), .P(p3), .OUT_VALID(v3), .OVF(o3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass = n_pass + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc_op(input logic [17:0] ta, input logic [17:0] tb, input logic tclr);
    a        = ta;
    b        = tb;
    acc_clr  = tclr;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    repeat (3) tick();
  endtask

  logic        s_vin [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        s_clr [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [39:0] s_expp[6] = '{40'd4, 40'd8, 40'd12, 40'd12, 40'd4, 40'd4};
  logic        s_expv[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    arst_n = 1'b0; srst_n = 1'b1; ce = 1'b1;
    a = 18'd0; b = 18'd0; c = 40'd0; in_valid = 1'b0; acc_clr = 1'b0;
    #3;
    check("rst_p0", p0, 40'd0);
    check("rst_v0", 40'(v0), 40'd0);
    check("rst_o0", 40'(o0), 40'd0);
    check("rst_p2", p2, 40'd0);
    check("rst_v2", 40'(v2), 40'd0);
    check("rst_v3", 40'(v3), 40'd0);
    tick();
    arst_n = 1'b1;
    tick();

    // signed -3 * 5 through the default 2-cycle pipe
    a = 18'h3FFFD; b = 18'd5; in_valid = 1'b1;
    #1;
    check("comb_neg_p1", p1, 40'hFFFFFFFFF1);
    check("comb_neg_v1", 40'(v1), 40'd1);
    tick();
    in_valid = 1'b0; a = 18'd0; b = 18'd0;
    check("lat_early_v0", 40'(v0), 40'd0);
    check("uns_p3", p3, 40'h000013FFF1);
    check("uns_v3", 40'(v3), 40'd1);
    check("uns_o3", 40'(o3), 40'd0);
    tick();
    check("lat2_v0", 40'(v0), 40'd1);
    check("lat2_p0", p0, 40'hFFFFFFFFF1);
    check("lat2_o0", 40'(o0), 40'd0);
    tick();
    check("lat3_v0", 40'(v0), 40'd0);

    // combinational ADDC
    a = 18'd2; b = 18'd3; c = 40'd10; in_valid = 1'b1;
    #1;
    check("addc_p1", p1, 40'd16);
    check("addc_v1", 40'(v1), 40'd1);
    c = 40'hFFFFFFFFEC;
    #1;
    check("addc_negc_p1", p1, 40'hFFFFFFFFF2);
    a = 18'h3FFFF; b = 18'd1; c = 40'h8000000000;
    #1;
`ifdef MAE_SAT_EN
    check("addc_min_p1", p1, 40'h8000000000);
    check("addc_min_o1", 40'(o1), 40'd1);
`else
    check("addc_min_p1", p1, 40'h7FFFFFFFFF);
    check("addc_min_o1", 40'(o1), 40'd0);
`endif
    in_valid = 1'b0;
    #1;
    check("addc_inv_v1", 40'(v1), 40'd0);
    a = 18'd0; b = 18'd0; c = 40'd0;
    tick();

    // synchronous clear while CE is low
    ce = 1'b0; srst_n = 1'b0;
    tick();
    srst_n = 1'b1; ce = 1'b1;
    check("srst_p2", p2, 40'd0);
    check("srst_v2", 40'(v2), 40'd0);
    check("srst_v0", 40'(v0), 40'd0);

    // accumulate with a bubble and a reload
    a = 18'd2; b = 18'd2;
    for (int i = 0; i < 8; i++) begin
      in_valid = s_vin[i];
      acc_clr  = s_clr[i];
      tick();
      if (i >= 2) begin
        check($sformatf("acc_p_%0d", i - 2), p2, s_expp[i-2]);
        check($sformatf("acc_v_%0d", i - 2), 40'(v2), 40'(s_expv[i-2]));
      end
    end

    // clock-enable freeze mid-stream
    acc_op(18'd1, 18'd3, 1'b1);
    acc_op(18'd1, 18'd5, 1'b0);
    acc_op(18'd1, 18'd7, 1'b0);
    check("ce_pre_p2", p2, 40'd3);
    ce = 1'b0; a = 18'd100; b = 18'd100; acc_clr = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ce_hold_p_%0d", k), p2, 40'd3);
      check($sformatf("ce_hold_v_%0d", k), 40'(v2), 40'd1);
    end
    ce = 1'b1; in_valid = 1'b0; acc_clr = 1'b0;
    tick();
    check("ce_res1_p2", p2, 40'd8);
    tick();
    check("ce_res2_p2", p2, 40'd15);
    check("ce_res2_v2", 40'(v2), 40'd1);
    tick();
    check("ce_res3_v2", 40'(v2), 40'd0);

    // build 2^39-2 then add 5
    acc_op(18'h20000, 18'h20000, 1'b1);
    repeat (30) acc_op(18'h20000, 18'h20000, 1'b0);
    acc_op(18'h20000, 18'h20001, 1'b0);
    acc_op(18'd1, 18'd131070, 1'b0);
    drain();
    check("near_max_p2", p2, 40'h7FFFFFFFFE);
    check("near_max_o2", 40'(o2), 40'd0);
    acc_op(18'd5, 18'd1, 1'b0);
    drain();
`ifdef MAE_SAT_EN
    check("ovf_p2", p2, 40'h7FFFFFFFFF);
    check("ovf_o2", 40'(o2), 40'd1);
`else
    check("ovf_p2", p2, 40'h8000000003);
    check("ovf_o2", 40'(o2), 40'd0);
`endif
    check("ovf_bubble_v2", 40'(v2), 40'd0);
    acc_op(18'd7, 18'd1, 1'b1);
    drain();
    check("post_ovf_p2", p2, 40'd7);
    check("post_ovf_o2", 40'(o2), 40'd0);

    // async reset mid-accumulation
    acc_op(18'd3, 18'd3, 1'b0);
    in_valid = 1'b0;
    tick();
    arst_n = 1'b0;
    #1;
    check("arst_p2", p2, 40'd0);
    check("arst_v2", 40'(v2), 40'd0);
    check("arst_o2", 40'(o2), 40'd0);
    tick();
    tick();
    check("arst_hold_p2", p2, 40'd0);
    arst_n = 1'b1;
    tick();
    acc_op(18'd2, 18'd6, 1'b1);
    in_valid = 1'b0; acc_clr = 1'b0;
    tick();
    tick();
    check("arst_reload_p2", p2, 40'd12);
    check("arst_reload_v2", 40'(v2), 40'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
